// File: rtl/ttt_pkg.sv
// Shared cell/result codes, FSM encoding and winning-line table for the tic-tac-toe controller.
// Pure definitions: no latency, no flow control.
package ttt_pkg;

  typedef logic [1:0] cell_t;
  typedef logic [3:0] idx_t;

  localparam cell_t CELL_EMPTY = 2'd0;
  localparam cell_t CELL_O     = 2'd1;
  localparam cell_t CELL_X     = 2'd2;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_O    = 2'd1;
  localparam logic [1:0] WIN_X    = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  localparam idx_t NUM_CELLS = 4'd9;
  localparam int   NUM_LINES = 8;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  // Three rows, three columns, then the two diagonals.
  localparam idx_t WIN_LINES [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [1:0] col_of(input idx_t i);
    case (i)
      4'd0, 4'd3, 4'd6: col_of = 2'd0;
      4'd1, 4'd4, 4'd7: col_of = 2'd1;
      default:          col_of = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Flags whether any of the eight board lines is fully owned by the given player.
// Purely combinational, zero latency; no flow control.
module ttt_line_check
  import ttt_pkg::*;
(
  input  cell_t [8:0] cells,
  input  cell_t       player,
  output logic        win
);

  always_comb begin
    win = 1'b0;
    for (int l = 0; l < NUM_LINES; l++) begin
      if (cells[WIN_LINES[l][0]] == player &&
          cells[WIN_LINES[l][1]] == player &&
          cells[WIN_LINES[l][2]] == player)
        win = 1'b1;
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe sequencer: cursor, mark placement and win/draw detection; cells visible one edge after a place, result one edge later.
// Button pulses are consumed every cycle (no backpressure); pulses arriving in CHECK/OVER other than btn_new are dropped.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER = 2'd2,
  parameter logic [3:0] START_CURSOR = 4'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_place,
  input  logic       btn_new,
  output logic [1:0] a1,
  output logic [1:0] a2,
  output logic [1:0] a3,
  output logic [1:0] a4,
  output logic [1:0] a5,
  output logic [1:0] a6,
  output logic [1:0] a7,
  output logic [1:0] a8,
  output logic [1:0] a9,
  output logic [3:0] cursor,
  output logic [1:0] turn,
  output logic [1:0] winner,
  output logic       game_over
);

  state_t      state_q,    state_d;
  cell_t [8:0] cells_q,    cells_d;
  idx_t        cursor_q,   cursor_d;
  cell_t       turn_q,     turn_d;
  logic [1:0]  winner_q,   winner_d;
  logic [3:0]  move_cnt_q, move_cnt_d;
  logic        line_win;

  ttt_line_check u_line_check (
    .cells  (cells_q),
    .player (turn_q),
    .win    (line_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PLAY;
      cells_q    <= '0;
      cursor_q   <= START_CURSOR;
      turn_q     <= FIRST_PLAYER;
      winner_q   <= WIN_NONE;
      move_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      cells_q    <= cells_d;
      cursor_q   <= cursor_d;
      turn_q     <= turn_d;
      winner_q   <= winner_d;
      move_cnt_q <= move_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cells_d    = cells_q;
    cursor_d   = cursor_q;
    turn_d     = turn_q;
    winner_d   = winner_q;
    move_cnt_d = move_cnt_q;
    if (btn_new) begin
      state_d    = ST_PLAY;
      cells_d    = '0;
      cursor_d   = START_CURSOR;
      turn_d     = FIRST_PLAYER;
      winner_d   = WIN_NONE;
      move_cnt_d = 4'd0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          // An ignored place on an occupied cell still masks lower-priority moves.
          if (btn_place) begin
            if (cells_q[cursor_q] == CELL_EMPTY) begin
              cells_d[cursor_q] = turn_q;
              if (move_cnt_q != NUM_CELLS)
                move_cnt_d = move_cnt_q + 4'd1;
              state_d = ST_CHECK;
            end
          end else if (btn_up) begin
            if (cursor_q >= 4'd3) cursor_d = cursor_q - 4'd3;
          end else if (btn_down) begin
            if (cursor_q <= 4'd5) cursor_d = cursor_q + 4'd3;
          end else if (btn_left) begin
            if (col_of(cursor_q) != 2'd0) cursor_d = cursor_q - 4'd1;
          end else if (btn_right) begin
            if (col_of(cursor_q) != 2'd2) cursor_d = cursor_q + 4'd1;
          end
        end
        ST_CHECK: begin
          state_d = ST_OVER;
          if (line_win)
            winner_d = turn_q;
          else if (move_cnt_q == NUM_CELLS)
            winner_d = WIN_DRAW;
          else begin
            turn_d  = (turn_q == CELL_O) ? CELL_X : CELL_O;
            state_d = ST_PLAY;
          end
        end
        ST_OVER: ;
        default: state_d = ST_PLAY;
      endcase
    end
  end

  always_comb begin
    a1        = cells_q[0];
    a2        = cells_q[1];
    a3        = cells_q[2];
    a4        = cells_q[3];
    a5        = cells_q[4];
    a6        = cells_q[5];
    a7        = cells_q[6];
    a8        = cells_q[7];
    a9        = cells_q[8];
    cursor    = cursor_q;
    turn      = turn_q;
    winner    = winner_q;
    game_over = (state_q == ST_OVER);
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed plus random bench for ttt_game_ctrl, checked cycle by cycle against a rule-level game model.
module tb_ttt_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_down, btn_left, btn_right, btn_place, btn_new;
  logic [1:0] a [9];
  logic [3:0] cursor;
  logic [1:0] turn, winner;
  logic       game_over;

  localparam logic [5:0] B_NEW   = 6'b100000;
  localparam logic [5:0] B_PLACE = 6'b010000;
  localparam logic [5:0] B_UP    = 6'b001000;
  localparam logic [5:0] B_DOWN  = 6'b000100;
  localparam logic [5:0] B_LEFT  = 6'b000010;
  localparam logic [5:0] B_RIGHT = 6'b000001;

  int errors = 0;
  int checks = 0;

  ttt_game_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_place (btn_place),
    .btn_new   (btn_new),
    .a1        (a[0]),
    .a2        (a[1]),
    .a3        (a[2]),
    .a4        (a[3]),
    .a5        (a[4]),
    .a6        (a[5]),
    .a7        (a[6]),
    .a8        (a[7]),
    .a9        (a[8]),
    .cursor    (cursor),
    .turn      (turn),
    .winner    (winner),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  // Game model: board as plain ints, row/col arithmetic, explicit "result pending" flag.
  int m_board [9];
  int m_cur, m_turn, m_win, m_moves;
  bit m_pending, m_over;

  function automatic void m_reset();
    for (int i = 0; i < 9; i++) m_board[i] = 0;
    m_cur = 4; m_turn = 2; m_win = 0; m_moves = 0;
    m_pending = 0; m_over = 0;
  endfunction

  function automatic bit m_has_line(int p);
    bit found = 0;
    for (int k = 0; k < 3; k++) begin
      if (m_board[3*k] == p && m_board[3*k+1] == p && m_board[3*k+2] == p) found = 1;
      if (m_board[k] == p && m_board[k+3] == p && m_board[k+6] == p) found = 1;
    end
    if (m_board[0] == p && m_board[4] == p && m_board[8] == p) found = 1;
    if (m_board[2] == p && m_board[4] == p && m_board[6] == p) found = 1;
    return found;
  endfunction

  function automatic void m_step(logic [5:0] b);
    int row, col;
    row = m_cur / 3;
    col = m_cur % 3;
    if (b[5]) m_reset();
    else if (m_pending) begin
      m_pending = 0;
      if (m_has_line(m_turn)) begin m_win = m_turn; m_over = 1; end
      else if (m_moves == 9) begin m_win = 3; m_over = 1; end
      else m_turn = 3 - m_turn;
    end else if (m_over) begin
    end else if (b[4]) begin
      if (m_board[m_cur] == 0) begin
        m_board[m_cur] = m_turn;
        m_moves = m_moves + 1;
        m_pending = 1;
      end
    end else if (b[3]) begin if (row > 0) m_cur -= 3; end
    else if (b[2]) begin if (row < 2) m_cur += 3; end
    else if (b[1]) begin if (col > 0) m_cur -= 1; end
    else if (b[0]) begin if (col < 2) m_cur += 1; end
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 9; i++) check($sformatf("a%0d", i + 1), {2'b00, a[i]}, 4'(m_board[i]));
    check("cursor", cursor, 4'(m_cur));
    check("turn", {2'b00, turn}, 4'(m_turn));
    check("winner", {2'b00, winner}, 4'(m_win));
    check("game_over", {3'b000, game_over}, {3'b000, m_over});
  endtask

  task automatic step(input logic [5:0] b);
    {btn_new, btn_place, btn_up, btn_down, btn_left, btn_right} = b;
    @(posedge clk);
    #1;
    {btn_new, btn_place, btn_up, btn_down, btn_left, btn_right} = '0;
    m_step(b);
    check_all();
  endtask

  task automatic goto_cell(input int target);
    for (int n = 0; n < 8 && m_cur != target; n++) begin
      if (m_cur / 3 > target / 3)      step(B_UP);
      else if (m_cur / 3 < target / 3) step(B_DOWN);
      else if (m_cur % 3 > target % 3) step(B_LEFT);
      else                             step(B_RIGHT);
    end
  endtask

  task automatic play(input int target);
    goto_cell(target);
    step(B_PLACE);
    step(6'b0);
  endtask

  initial begin
    logic [5:0] b;
    int r;
    int draw_seq [9];
    draw_seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

    rst_n = 1'b0;
    {btn_new, btn_place, btn_up, btn_down, btn_left, btn_right} = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(6'b0);
    step(6'b0);

    // Cursor clamps at the board edges.
    step(B_UP); step(B_UP); step(B_LEFT); step(B_LEFT);
    check("clamp_top_left", cursor, 4'd0);
    step(B_DOWN); step(B_DOWN); step(B_DOWN);
    check("clamp_bottom", cursor, 4'd6);

    // Re-placing on an occupied cell is ignored.
    play(4);
    check("occ_first_turn", {2'b00, turn}, 4'd1);
    step(B_PLACE);
    step(6'b0);
    check("occ_cell_kept", {2'b00, a[4]}, 4'd2);
    check("occ_turn_kept", {2'b00, turn}, 4'd1);

    // X wins on the top row; afterwards the game is frozen.
    step(B_NEW);
    play(0); play(3); play(1); play(4); play(2);
    check("xwin_winner", {2'b00, winner}, 4'd2);
    check("xwin_over", {3'b000, game_over}, 4'd1);
    step(B_PLACE); step(B_UP); step(B_LEFT | B_PLACE); step(B_DOWN);
    step(B_NEW | B_PLACE);
    check("new_in_over_cursor", cursor, 4'd4);
    check("new_in_over_winner", {2'b00, winner}, 4'd0);

    // Nine moves with no completed line end in a draw.
    foreach (draw_seq[i]) play(draw_seq[i]);
    check("draw_winner", {2'b00, winner}, 4'd3);
    check("draw_over", {3'b000, game_over}, 4'd1);

    // btn_new beats btn_place during PLAY.
    step(B_NEW);
    goto_cell(0);
    step(B_NEW | B_PLACE);
    check("new_beats_place_cell", {2'b00, a[0]}, 4'd0);
    check("new_beats_place_cursor", cursor, 4'd4);

    // Asynchronous reset while the result is pending.
    goto_cell(2);
    {btn_place} = 1'b1;
    @(posedge clk);
    #1;
    btn_place = 1'b0;
    m_step(B_PLACE);
    check("pre_reset_cell", {2'b00, a[2]}, 4'd2);
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(6'b0);

    // Random pulse traffic, including simultaneous buttons.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2)       b = B_NEW | 6'($urandom_range(0, 31));
      else if (r < 35) b = B_PLACE | 6'($urandom_range(0, 15) & ($urandom_range(0, 3) == 0 ? 15 : 0));
      else if (r < 85) b = 6'($urandom_range(0, 15));
      else             b = 6'b0;
      step(b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
